// File: rtl/halt_pkg.sv
// Shared types and cause-code helpers for the halt/trap controller.
package halt_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2,
    RESUME = 2'd3
  } state_t;

  // Hardware causes occupy codes 0..n-1; the two synthetic causes sit just above them.
  function automatic int code_dbg(input int n);
    return n;
  endfunction

  function automatic int code_step(input int n);
    return n + 1;
  endfunction

endpackage

// File: rtl/halt_prio_enc.sv
// Lowest-index-first priority encoder: bit 0 of req has the highest priority.
module halt_prio_enc #(
  parameter int N     = 4,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     req,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/halt_ctrl.sv
// Halt/trap controller: prioritised maskable causes, debugger halt and single-step,
// with drain-then-halt sequencing and a resume handshake.
module halt_ctrl
  import halt_pkg::*;
#(
  parameter  int NUM_CAUSES = 4,
  parameter  int PC_W       = 32,
  parameter  int STEP_W     = 8,
  localparam int CODE_W     = $clog2(NUM_CAUSES + 2)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_CAUSES-1:0] cause_i,
  input  logic [NUM_CAUSES-1:0] cause_en_i,
  input  logic [PC_W-1:0]       pc_i,
  input  logic [PC_W-1:0]       tval_i,
  input  logic                  retire_i,
  input  logic                  pipe_idle_i,
  input  logic                  dbg_halt_req_i,
  input  logic                  resume_req_i,
  input  logic [STEP_W-1:0]     step_n_i,
  output logic                  stall_o,
  output logic                  halted_o,
  output logic                  resume_ack_o,
  output logic [CODE_W-1:0]     cause_o,
  output logic [PC_W-1:0]       epc_o,
  output logic [PC_W-1:0]       tval_o,
  output logic                  overflow_o
);

  state_t                  state, state_next;
  logic [STEP_W-1:0]       step_cnt;
  logic                    step_active;
  logic [NUM_CAUSES-1:0]   masked;
  logic                    hw_valid;
  logic [CODE_W-1:0]       hw_idx;
  logic                    step_done;
  logic                    trigger;
  logic [CODE_W-1:0]       win_code;

  assign masked    = cause_i & cause_en_i;
  assign step_done = step_active & retire_i & (step_cnt == STEP_W'(1));
  assign trigger   = hw_valid | dbg_halt_req_i | step_done;

  halt_prio_enc #(
    .N     (NUM_CAUSES),
    .IDX_W (CODE_W)
  ) u_prio_enc (
    .req   (masked),
    .valid (hw_valid),
    .idx   (hw_idx)
  );

  always_comb begin
    win_code = CODE_W'(code_step(NUM_CAUSES));
    if (hw_valid)
      win_code = hw_idx;
    else if (dbg_halt_req_i)
      win_code = CODE_W'(code_dbg(NUM_CAUSES));
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (trigger) state_next = DRAIN;
      DRAIN:   if (pipe_idle_i) state_next = HALTED;
      HALTED:  if (resume_req_i) state_next = RESUME;
      RESUME:  state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // Status outputs are registered copies of the next-state decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= RUN;
      stall_o      <= 1'b0;
      halted_o     <= 1'b0;
      resume_ack_o <= 1'b0;
    end else begin
      state        <= state_next;
      stall_o      <= (state_next != RUN);
      halted_o     <= (state_next == HALTED);
      resume_ack_o <= (state_next == RESUME);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cause_o <= '0;
      epc_o   <= '0;
      tval_o  <= '0;
    end else if (state == RUN && trigger) begin
      cause_o <= win_code;
      epc_o   <= pc_i;
      tval_o  <= tval_i;
    end
  end

  // Accepting a resume clears the sticky flag; later triggers outside RUN set it again.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      overflow_o <= 1'b0;
    else if (state == HALTED && resume_req_i)
      overflow_o <= 1'b0;
    else if (state != RUN && trigger)
      overflow_o <= 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_cnt    <= '0;
      step_active <= 1'b0;
    end else if (state == RESUME) begin
      step_cnt    <= step_n_i;
      step_active <= (step_n_i != '0);
    end else if (state == RUN) begin
      if (step_active && retire_i)
        step_cnt <= step_cnt - STEP_W'(1);
      if (trigger)
        step_active <= 1'b0;
    end
  end

endmodule

// File: tb/tb_halt_ctrl.sv
// Directed self-checking bench for halt_ctrl with hand-computed expected values.
module tb_halt_ctrl;

  localparam int NUM_CAUSES = 4;
  localparam int PC_W       = 32;
  localparam int STEP_W     = 8;
  localparam int CODE_W     = $clog2(NUM_CAUSES + 2);

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NUM_CAUSES-1:0] cause_i;
  logic [NUM_CAUSES-1:0] cause_en_i;
  logic [PC_W-1:0]       pc_i;
  logic [PC_W-1:0]       tval_i;
  logic                  retire_i;
  logic                  pipe_idle_i;
  logic                  dbg_halt_req_i;
  logic                  resume_req_i;
  logic [STEP_W-1:0]     step_n_i;
  logic                  stall_o;
  logic                  halted_o;
  logic                  resume_ack_o;
  logic [CODE_W-1:0]     cause_o;
  logic [PC_W-1:0]       epc_o;
  logic [PC_W-1:0]       tval_o;
  logic                  overflow_o;

  int testsRun    = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  halt_ctrl #(
    .NUM_CAUSES (NUM_CAUSES),
    .PC_W       (PC_W),
    .STEP_W     (STEP_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cause_i        (cause_i),
    .cause_en_i     (cause_en_i),
    .pc_i           (pc_i),
    .tval_i         (tval_i),
    .retire_i       (retire_i),
    .pipe_idle_i    (pipe_idle_i),
    .dbg_halt_req_i (dbg_halt_req_i),
    .resume_req_i   (resume_req_i),
    .step_n_i       (step_n_i),
    .stall_o        (stall_o),
    .halted_o       (halted_o),
    .resume_ack_o   (resume_ack_o),
    .cause_o        (cause_o),
    .epc_o          (epc_o),
    .tval_o         (tval_o),
    .overflow_o     (overflow_o)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then advance to 1 ns after the next rising edge.
  task automatic applyStimulus(input logic [3:0] cause, input logic [3:0] en, input logic dbg,
                               input logic resume, input logic retire, input logic idle,
                               input logic [31:0] pc, input logic [31:0] tval);
    cause_i        = cause;
    cause_en_i     = en;
    dbg_halt_req_i = dbg;
    resume_req_i   = resume;
    retire_i       = retire;
    pipe_idle_i    = idle;
    pc_i           = pc;
    tval_i         = tval;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset          = 1'b1;
    cause_i        = '0;
    cause_en_i     = '0;
    pc_i           = '0;
    tval_i         = '0;
    retire_i       = 1'b0;
    pipe_idle_i    = 1'b0;
    dbg_halt_req_i = 1'b0;
    resume_req_i   = 1'b0;
    step_n_i       = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    checkOutput("rst_stall",    stall_o,      0);
    checkOutput("rst_halted",   halted_o,     0);
    checkOutput("rst_ack",      resume_ack_o, 0);
    checkOutput("rst_cause",    cause_o,      0);
    checkOutput("rst_epc",      epc_o,        0);
    checkOutput("rst_tval",     tval_o,       0);
    checkOutput("rst_overflow", overflow_o,   0);

    // Basic halt on cause 2 with a slow drain; resume pulse in DRAIN must be ignored.
    applyStimulus(4'b0100, 4'hF, 0, 0, 0, 0, 32'h100, 32'h33);
    checkOutput("t1_stall",  stall_o,  1);
    checkOutput("t1_halted", halted_o, 0);
    checkOutput("t1_cause",  cause_o,  2);
    checkOutput("t1_epc",    epc_o,    32'h100);
    checkOutput("t1_tval",   tval_o,   32'h33);
    applyStimulus(4'b0000, 4'hF, 0, 0, 0, 0, 0, 0);
    checkOutput("t1_drain_halted", halted_o, 0);
    applyStimulus(4'b0000, 4'hF, 0, 1, 0, 0, 0, 0);
    checkOutput("drain_resume_ack",    resume_ack_o, 0);
    checkOutput("drain_resume_halted", halted_o,     0);
    applyStimulus(4'b0000, 4'hF, 0, 0, 0, 1, 0, 0);
    checkOutput("t1_halted_after_idle", halted_o,     1);
    checkOutput("t1_halted_stall",      stall_o,      1);
    checkOutput("t1_halted_ack",        resume_ack_o, 0);

    // Resume handshake, free run.
    step_n_i = 8'd0;
    applyStimulus(4'b0000, 4'hF, 0, 1, 0, 1, 0, 0);
    checkOutput("res_ack",    resume_ack_o, 1);
    checkOutput("res_halted", halted_o,     0);
    checkOutput("res_stall",  stall_o,      1);
    applyStimulus(4'b0000, 4'hF, 0, 0, 0, 1, 0, 0);
    checkOutput("res_ack_gone", resume_ack_o, 0);
    checkOutput("res_run_stall", stall_o,     0);
    checkOutput("res_overflow",  overflow_o,  0);
    checkOutput("res_cause_held", cause_o,    2);

    // Masked cause must not halt.
    applyStimulus(4'b0001, 4'b1110, 0, 0, 0, 1, 32'h180, 0);
    checkOutput("masked_stall1", stall_o, 0);
    applyStimulus(4'b0001, 4'b1110, 0, 0, 0, 1, 32'h180, 0);
    checkOutput("masked_stall2", stall_o, 0);

    // Enabled cause 3 beats debug request; causes 1 is masked.
    applyStimulus(4'b1010, 4'b1101, 1, 0, 0, 1, 32'h200, 32'h44);
    checkOutput("simul_cause", cause_o, 3);
    checkOutput("simul_epc",   epc_o,   32'h200);
    checkOutput("simul_tval",  tval_o,  32'h44);
    checkOutput("simul_stall", stall_o, 1);
    applyStimulus(4'b0000, 4'hF, 0, 0, 0, 1, 0, 0);
    checkOutput("simul_halted",   halted_o,   1);
    checkOutput("simul_overflow", overflow_o, 0);

    // Single step of 3 with a gap between retires.
    step_n_i = 8'd3;
    applyStimulus(4'b0000, 4'hF, 0, 1, 0, 1, 0, 0);
    checkOutput("step1_ack", resume_ack_o, 1);
    applyStimulus(4'b0000, 4'hF, 0, 0, 0, 1, 0, 0);
    checkOutput("step1_run", stall_o, 0);
    applyStimulus(4'b0000, 4'hF, 0, 0, 1, 1, 32'h300, 0);
    checkOutput("step1_r1", stall_o, 0);
    applyStimulus(4'b0000, 4'hF, 0, 0, 0, 1, 32'h302, 0);
    checkOutput("step1_gap", stall_o, 0);
    applyStimulus(4'b0000, 4'hF, 0, 0, 1, 1, 32'h304, 0);
    checkOutput("step1_r2", stall_o, 0);
    applyStimulus(4'b0000, 4'hF, 0, 0, 1, 1, 32'h308, 32'h55);
    checkOutput("step1_stall", stall_o, 1);
    checkOutput("step1_cause", cause_o, 5);
    checkOutput("step1_epc",   epc_o,   32'h308);
    checkOutput("step1_tval",  tval_o,  32'h55);
    applyStimulus(4'b0000, 4'hF, 0, 0, 0, 1, 0, 0);
    checkOutput("step1_halted", halted_o, 1);

    // Same step budget, hardware cause 1 coincides with the final retire.
    applyStimulus(4'b0000, 4'hF, 0, 1, 0, 1, 0, 0);
    checkOutput("step2_ack", resume_ack_o, 1);
    applyStimulus(4'b0000, 4'hF, 0, 0, 0, 1, 0, 0);
    applyStimulus(4'b0000, 4'hF, 0, 0, 1, 1, 32'h310, 0);
    applyStimulus(4'b0000, 4'hF, 0, 0, 1, 1, 32'h314, 0);
    checkOutput("step2_r2", stall_o, 0);
    applyStimulus(4'b0010, 4'hF, 0, 0, 1, 1, 32'h318, 32'h66);
    checkOutput("step2_cause", cause_o, 1);
    checkOutput("step2_epc",   epc_o,   32'h318);
    applyStimulus(4'b0000, 4'hF, 0, 0, 0, 1, 0, 0);
    checkOutput("step2_halted", halted_o, 1);

    // Back to free run; retires must not halt.
    step_n_i = 8'd0;
    applyStimulus(4'b0000, 4'hF, 0, 1, 0, 1, 0, 0);
    applyStimulus(4'b0000, 4'hF, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++)
      applyStimulus(4'b0000, 4'hF, 0, 0, 1, 1, 32'h320 + 4 * i, 0);
    checkOutput("freerun_stall", stall_o, 0);

    // Overflow: second cause during DRAIN sets the flag but keeps the latched values.
    applyStimulus(4'b0001, 4'hF, 0, 0, 0, 0, 32'h400, 32'h11);
    checkOutput("ovf_cause0", cause_o, 0);
    checkOutput("ovf_epc0",   epc_o,   32'h400);
    applyStimulus(4'b0010, 4'hF, 0, 0, 0, 0, 32'h500, 32'h22);
    checkOutput("ovf_set",    overflow_o, 1);
    checkOutput("ovf_cause",  cause_o,    0);
    checkOutput("ovf_epc",    epc_o,      32'h400);
    checkOutput("ovf_tval",   tval_o,     32'h11);
    applyStimulus(4'b0000, 4'hF, 0, 0, 0, 1, 0, 0);
    checkOutput("ovf_halted", halted_o,   1);
    checkOutput("ovf_held",   overflow_o, 1);
    applyStimulus(4'b0000, 4'hF, 0, 1, 0, 1, 0, 0);
    checkOutput("ovf_res_ack",   resume_ack_o, 1);
    checkOutput("ovf_res_clear", overflow_o,   0);
    applyStimulus(4'b0000, 4'hF, 0, 0, 0, 1, 0, 0);
    checkOutput("ovf_run_stall", stall_o,    0);
    checkOutput("ovf_run_clear", overflow_o, 0);

    // Asynchronous reset while HALTED.
    applyStimulus(4'b0001, 4'hF, 0, 0, 0, 1, 32'h600, 32'h77);
    checkOutput("arst_stall", stall_o, 1);
    applyStimulus(4'b0000, 4'hF, 0, 0, 0, 1, 0, 0);
    checkOutput("arst_halted_pre", halted_o, 1);
    #2 reset = 1'b1;
    #1;
    checkOutput("arst_halted", halted_o, 0);
    checkOutput("arst_stall0", stall_o,  0);
    checkOutput("arst_epc",    epc_o,    0);
    checkOutput("arst_tval",   tval_o,   0);
    @(posedge clk);
    #1 reset = 1'b0;
    applyStimulus(4'b0000, 4'hF, 0, 0, 0, 1, 0, 0);
    checkOutput("arst_run", stall_o, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/halt_ctrl.md
Name: halt_ctrl

Overview:
- Parametrised halt/trap controller that replaces the single-bit halt flag.
- Accepts N prioritised, maskable halt causes, plus a debugger halt request and a single-step budget.
- On a trigger it latches the cause code, PC and trap value, stalls the front end, waits for the pipeline to drain, then holds the core halted until a resume handshake.
- Sits in the controller beside the decoder; its outputs feed the fetch/issue stall logic and the debug/CSR read-out.

Parameters:
NUM_CAUSES, 4, number of hardware halt cause inputs (bit 0 = highest priority); must be >= 1
PC_W, 32, width of PC and trap value
STEP_W, 8, width of the single-step counter
CODE_W, $clog2(NUM_CAUSES+2), derived cause-code width; not to be overridden

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
cause_i  in  NUM_CAUSES  per-cause halt event, level, sampled in RUN only
cause_en_i  in  NUM_CAUSES  per-cause enable mask; 0 = cause ignored
pc_i  in  PC_W  PC of the instruction raising the cause this cycle
tval_i  in  PC_W  trap value (e.g. faulting address) this cycle
retire_i  in  1  one instruction retired this cycle
pipe_idle_i  in  1  no instructions in flight
dbg_halt_req_i  in  1  debugger halt request, level
resume_req_i  in  1  resume request, single-cycle pulse
step_n_i  in  STEP_W  instructions to execute after resume; 0 = free run
stall_o  out  1  freeze fetch/issue
halted_o  out  1  core fully halted
resume_ack_o  out  1  one-cycle pulse when resume is accepted
cause_o  out  CODE_W  latched cause code
epc_o  out  PC_W  latched PC
tval_o  out  PC_W  latched trap value
overflow_o  out  1  sticky: further trigger seen while not in RUN

Behaviour:
- Async reset sets state to RUN and clears every output and the step counter to 0.
- Cause codes:
  - 0..NUM_CAUSES-1 = hardware cause index.
  - NUM_CAUSES = debug request.
  - NUM_CAUSES+1 = step complete.
- Trigger (evaluated in RUN only): any (cause_i & cause_en_i), or dbg_halt_req_i, or step_done.
  - step_done = step_active & retire_i & (step_cnt == 1).
- Priority: lowest-index enabled cause, then debug request, then step complete.
- States:
  - RUN: stall_o=0. On a trigger, the next edge latches cause_o (winning code), epc_o=pc_i and tval_o=tval_i, and moves to DRAIN. Registered outputs, so stall_o rises one cycle after the trigger cycle.
  - DRAIN: stall_o=1, halted_o=0. Move to HALTED on the first cycle pipe_idle_i=1. resume_req_i is ignored here, not queued.
  - HALTED: stall_o=1, halted_o=1. On resume_req_i, move to RESUME.
  - RESUME: exactly one cycle. stall_o=1, halted_o=0, resume_ack_o=1, overflow_o cleared. Step counter loads step_n_i; step_active = (step_n_i != 0). Next state is RUN.
- Latched cause_o/epc_o/tval_o hold from capture until the next capture; resume does not clear them.
- Any trigger condition while in DRAIN, HALTED or RESUME sets overflow_o; it never changes the latched values.
- Step counter:
  - Decrements on retire_i in RUN while step_active.
  - Halting for any reason clears step_active.
  - A hardware cause in the same cycle as step_done wins, and its code is latched.
- dbg_halt_req_i still high in the first RUN cycle after RESUME re-triggers immediately; this is intended.
- Reset mid-DRAIN or mid-HALTED returns to RUN with all state cleared.

Decomposition:
- Package halt_pkg holds:
  - state_t enum {RUN, DRAIN, HALTED, RESUME};
  - function code_dbg(n)=n;
  - function code_step(n)=n+1.
- One sub-module: halt_prio_enc, a parametrised lowest-index-first priority encoder (NUM_CAUSES in; valid plus index out).

Test Plan:
- Reset check: after reset, all outputs are 0. Pulse cause_i[2] with cause_en_i=4'b1111, pc_i=0x100, tval_i=0x33, hold pipe_idle_i=0 for 3 cycles. Required: stall_o=1 next cycle; halted_o=0 during drain; halted_o=1 the cycle after pipe_idle_i rises; cause_o=2, epc_o=0x100, tval_o=0x33.
- Simultaneous causes: cause_i=4'b1010 with cause_en_i=4'b1101 and dbg_halt_req_i=1. Required: cause_o=3.
- Masked cause: cause_i[0]=1 with cause_en_i[0]=0. Required: no halt.
- Resume handshake: resume_req_i pulse in HALTED. Required: resume_ack_o=1 for exactly one cycle, then stall_o=0, overflow_o=0.
- Resume ignored in DRAIN: resume_req_i pulse in DRAIN. Required: no ack; the core still reaches HALTED.
- Single step: resume with step_n_i=3, retire_i on 3 separate cycles. Required: halt with cause_o=NUM_CAUSES+1 (5 for the default), epc_o = pc_i of the third retire. Repeat with cause_i[1] on the third retire cycle: cause_o=1.
- Overflow: cause_i[0] in RUN, then cause_i[1] during DRAIN. Required: cause_o stays 0, overflow_o=1 until resume. Assert reset while HALTED: halted_o=0 asynchronously.
